load_buffer: RTL and testbench
==============================

# load_buffer

In-order load queue sitting directly upstream of the load unit in the Tomasulo back end. Accepts dispatched loads whose base register may still be pending on a ROB tag, and snoops the CDB to capture the missing base values. Computes effective addresses and issues loads strictly in program order to the load unit, one `loadEnable` pulse per load, respecting the load unit's `busy`.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, minimum 2.
- `TAGW`, 6: ROB tag width.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `flush`  in  1: mispredict flush; synchronous, clears the queue.
- `dispatchEnable`  in  1: dispatch request for one load this cycle.
- `loadType`  in  3: LB/LH/LW/LBU/LHU encoding.
- `baseReady`  in  1: `baseValue` is valid; if 0, wait on `baseTag`.
- `baseValue`  in  32: base register value.
- `baseTag`  in  TAGW: ROB tag producing the base.
- `offset`  in  32: sign-extended immediate.
- `robNum`  in  TAGW: ROB entry of this load.
- `full`  out  1: registered; no free entry.
- `empty`  out  1: registered; no valid entry.
- `cdbEnable`  in  1: CDB broadcast valid.
- `cdbRobNum`  in  TAGW: broadcast tag.
- `cdbData`  in  32: broadcast value.
- `luBusy`  in  1: load unit `busy`.
- `loadEnable`  out  1: single-cycle issue pulse to the load unit.
- `loadType_out`  out  3: type of the issued load.
- `addr_out`  out  32: effective address.
- `robNum_out`  out  TAGW: ROB entry of the issued load.
- `excValid`  out  1: misalignment report pulse (see Configuration).
- `excRobNum`  out  TAGW: ROB entry of the faulting load.

## Operation
- Circular FIFO: `head`, `tail` pointers of log2(DEPTH) bits, wrap modulo DEPTH; `count` of log2(DEPTH)+1 bits.
- Entry fields: valid, ready, type, tag, base, offset, robNum.
- Dispatch: accepted when `dispatchEnable` is 1 and `full` is 0; ignored when full (no overwrite, no error). Entry written at `tail`.
- Dispatch-time capture: if `baseReady` is 0 but `cdbEnable` is 1 with `cdbRobNum == baseTag` in the same cycle, the entry is written ready with `cdbData`.
- Snoop: every valid, not-ready entry whose tag matches a valid CDB broadcast captures `cdbData` and becomes ready. All entries snoop in parallel.
- Address: `base + offset`, 32-bit modulo-2^32, with the carry discarded.
- Issue rules: the head entry issues only when it is valid and ready, `luBusy` is 0, and `loadEnable` was 0 in the previous cycle.
- Issue state machine: IDLE → ISSUE (`loadEnable` is 1 for one cycle) → GAP (`loadEnable` is 0 for a mandatory cycle) → IDLE.
- No younger entry issues ahead of a non-ready head.
- On issue, the head entry is freed and `head` advances.
- Simultaneous dispatch and issue in the same cycle: both happen and `count` is unchanged.
- Flush: clears all valid bits, resets the pointers, forces `loadEnable` to 0, and returns the FSM to IDLE. Flush has priority over a dispatch in the same cycle.
- Reset: same effect as flush. All outputs go to 0, except `empty`, which goes to 1.

## Timing
- Dispatch with a ready base at edge N: the earliest `loadEnable` is high between edges N+1 and N+2.
- A CDB capture at edge N allows issue at the earliest from edge N+1.
- Back-to-back loads: at most one issue every 2 cycles, and fewer whenever `luBusy` is high.
- `loadType_out`, `addr_out`, `robNum_out`: registered, and stable from the rising edge of `loadEnable` until the next issue.
- `full` and `empty` reflect the state after the current edge, with no combinational path from `dispatchEnable`.

## Configuration
- `LB_ALIGN_CHECK_EN` defined:
  - A head LH/LHU with `addr[0]` set, or an LW with `addr[1:0]` nonzero, is not issued.
  - Instead, `excValid` pulses for one cycle with `excRobNum`, and the entry is freed.
  - This uses the same ISSUE/GAP slot and ignores `luBusy`.
- Undefined:
  - All addresses issue unchanged.
  - `excValid` and `excRobNum` are tied to 0.

## Structure
- Shared package `cpu_pkg`:
  - load type constants LBOp=000, LHOp=001, LWOp=010, LBUOp=100, LHUOp=101;
  - the ROB tag width;
  - the FSM state enum.
- Sub-module `lb_entry`: one entry's storage, CDB snoop/capture, and address adder. It is instantiated DEPTH times; the queue control logic lives in `load_buffer`.

## Test plan
- Dispatch LW base=0x100 ready, offset=0x8 → one `loadEnable` pulse 1 cycle later, with addr_out=0x108 and robNum_out equal to the dispatched value.
- Dispatch 1: base pending on tag 5. Dispatch 2: ready. Later a CDB broadcasts tag 5 data=0x2000 → load 1 issues first with addr 0x2000+offset, then load 2 issues after a 1-cycle gap.
- Dispatch with baseTag=7 while the same cycle's CDB carries tag 7 data=0x40 → entry ready immediately, issues with addr 0x40+offset.
- Fill 4 entries with `luBusy`=1 → `full`=1 and a 5th dispatch is dropped. Release `luBusy` → exactly 4 issues in order, then `empty`=1.
- Assert `flush` with 3 entries pending together with a same-cycle dispatch → no further `loadEnable`, `empty`=1 next cycle.
- Same flush behaviour when `reset_n`=0 mid-issue.
- With `LB_ALIGN_CHECK_EN`, LW addr 0x102 → `excValid` pulse with its robNum and no `loadEnable`. The following aligned LB issues normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared back-end definitions: load type encodings, ROB tag width, load buffer FSM states.
package cpu_pkg;

   localparam int unsigned ROB_TAGW = 6;

   localparam logic [2:0] LBOp  = 3'b000;
   localparam logic [2:0] LHOp  = 3'b001;
   localparam logic [2:0] LWOp  = 3'b010;
   localparam logic [2:0] LBUOp = 3'b100;
   localparam logic [2:0] LHUOp = 3'b101;

   typedef enum logic [1:0] {
      LB_IDLE  = 2'b00,
      LB_ISSUE = 2'b01,
      LB_GAP   = 2'b10
   } lb_state_t;

   function automatic logic misaligned(input logic [2:0] ltype, input logic [31:0] addr);
      case (ltype)
         LHOp, LHUOp: return addr[0];
         LWOp:        return |addr[1:0];
         default:     return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lb_entry.sv
// One load buffer slot: holds a dispatched load, snoops the CDB for a pending base,
// and presents base + offset as the effective address.
module lb_entry
   import cpu_pkg::*;
#(
   parameter int unsigned TAGW = ROB_TAGW
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            clear,
   input  logic            write,
   input  logic            free,
   input  logic [2:0]      in_type,
   input  logic            in_ready,
   input  logic [31:0]     in_base,
   input  logic [TAGW-1:0] in_tag,
   input  logic [31:0]     in_offset,
   input  logic [TAGW-1:0] in_rob,
   input  logic            cdbEnable,
   input  logic [TAGW-1:0] cdbRobNum,
   input  logic [31:0]     cdbData,
   output logic            valid,
   output logic            ready,
   output logic [2:0]      ltype,
   output logic [TAGW-1:0] robNum,
   output logic [31:0]     addr
);

   logic [TAGW-1:0] tag;
   logic [31:0]     base;
   logic [31:0]     offset;
   logic            cap_now;
   logic            snoop;

   // A broadcast in the dispatch cycle would otherwise be missed by the snoop below.
   assign cap_now = !in_ready && cdbEnable && (cdbRobNum == in_tag);
   assign snoop   = valid && !ready && cdbEnable && (cdbRobNum == tag);

   always_ff @(posedge clock) begin
      if (!reset_n || clear) begin
         valid <= 1'b0;
         ready <= 1'b0;
      end else if (write) begin
         valid  <= 1'b1;
         ready  <= in_ready || cap_now;
         ltype  <= in_type;
         tag    <= in_tag;
         base   <= in_ready ? in_base : cdbData;
         offset <= in_offset;
         robNum <= in_rob;
      end else if (free) begin
         valid <= 1'b0;
         ready <= 1'b0;
      end else if (snoop) begin
         ready <= 1'b1;
         base  <= cdbData;
      end
   end

   assign addr = base + offset;

endmodule

// File: rtl/load_buffer.sv
// In-order load queue feeding the load unit; issues one pulse per load with a gap cycle.
// Optional misalignment trap enabled by defining LB_ALIGN_CHECK_EN.
module load_buffer
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAGW  = ROB_TAGW
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            dispatchEnable,
   input  logic [2:0]      loadType,
   input  logic            baseReady,
   input  logic [31:0]     baseValue,
   input  logic [TAGW-1:0] baseTag,
   input  logic [31:0]     offset,
   input  logic [TAGW-1:0] robNum,
   output logic            full,
   output logic            empty,
   input  logic            cdbEnable,
   input  logic [TAGW-1:0] cdbRobNum,
   input  logic [31:0]     cdbData,
   input  logic            luBusy,
   output logic            loadEnable,
   output logic [2:0]      loadType_out,
   output logic [31:0]     addr_out,
   output logic [TAGW-1:0] robNum_out,
   output logic            excValid,
   output logic [TAGW-1:0] excRobNum
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] head, tail;
   logic [CW-1:0] count, count_next;
   lb_state_t     state;

   logic            e_valid [DEPTH];
   logic            e_ready [DEPTH];
   logic [2:0]      e_type  [DEPTH];
   logic [TAGW-1:0] e_rob   [DEPTH];
   logic [31:0]     e_addr  [DEPTH];

   logic dispatch_ok, head_ok, head_mis, issue_go;

   assign dispatch_ok = dispatchEnable && !full && !flush;
   assign head_ok     = e_valid[head] && e_ready[head] && (state != LB_ISSUE);
`ifdef LB_ALIGN_CHECK_EN
   assign head_mis    = misaligned(e_type[head], e_addr[head]);
`else
   assign head_mis    = 1'b0;
`endif
   // A trapping load only reports, so it does not wait for the load unit.
   assign issue_go    = !flush && head_ok && (head_mis || !luBusy);

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      lb_entry #(.TAGW(TAGW)) u_entry (
         .clock     (clock),
         .reset_n   (reset_n),
         .clear     (flush),
         .write     (dispatch_ok && (tail == PW'(i))),
         .free      (issue_go && (head == PW'(i))),
         .in_type   (loadType),
         .in_ready  (baseReady),
         .in_base   (baseValue),
         .in_tag    (baseTag),
         .in_offset (offset),
         .in_rob    (robNum),
         .cdbEnable (cdbEnable),
         .cdbRobNum (cdbRobNum),
         .cdbData   (cdbData),
         .valid     (e_valid[i]),
         .ready     (e_ready[i]),
         .ltype     (e_type[i]),
         .robNum    (e_rob[i]),
         .addr      (e_addr[i])
      );
   end

   always_comb begin
      count_next = count;
      if (dispatch_ok && !issue_go)
         count_next = count + CW'(1);
      else if (!dispatch_ok && issue_go)
         count_next = count - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head         <= '0;
         tail         <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         state        <= LB_IDLE;
         loadEnable   <= 1'b0;
         loadType_out <= '0;
         addr_out     <= '0;
         robNum_out   <= '0;
         excValid     <= 1'b0;
         excRobNum    <= '0;
      end else if (flush) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         full       <= 1'b0;
         empty      <= 1'b1;
         state      <= LB_IDLE;
         loadEnable <= 1'b0;
         excValid   <= 1'b0;
      end else begin
         if (issue_go)
            head <= head + PW'(1);
         if (dispatch_ok)
            tail <= tail + PW'(1);
         count      <= count_next;
         full       <= (count_next == CW'(DEPTH));
         empty      <= (count_next == '0);
         loadEnable <= issue_go && !head_mis;
         excValid   <= issue_go && head_mis;
         if (issue_go && !head_mis) begin
            loadType_out <= e_type[head];
            addr_out     <= e_addr[head];
            robNum_out   <= e_rob[head];
         end
         if (issue_go && head_mis)
            excRobNum <= e_rob[head];
         if (issue_go)
            state <= LB_ISSUE;
         else if (state == LB_ISSUE)
            state <= LB_GAP;
         else
            state <= LB_IDLE;
      end
   end

endmodule

// File: tb/tb_load_buffer.sv
// Scoreboard bench for load_buffer; the alignment scenario follows LB_ALIGN_CHECK_EN.
module tb_load_buffer;

   typedef struct {
      logic [2:0]  t;
      logic [31:0] a;
      logic [5:0]  r;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        dispatchEnable = 1'b0;
   logic [2:0]  loadType = 3'b0;
   logic        baseReady = 1'b0;
   logic [31:0] baseValue = '0;
   logic [5:0]  baseTag = '0;
   logic [31:0] offset = '0;
   logic [5:0]  robNum = '0;
   logic        full, empty;
   logic        cdbEnable = 1'b0;
   logic [5:0]  cdbRobNum = '0;
   logic [31:0] cdbData = '0;
   logic        luBusy = 1'b0;
   logic        loadEnable;
   logic [2:0]  loadType_out;
   logic [31:0] addr_out;
   logic [5:0]  robNum_out;
   logic        excValid;
   logic [5:0]  excRobNum;

   load_buffer #(.DEPTH(4), .TAGW(6)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .dispatchEnable(dispatchEnable), .loadType(loadType), .baseReady(baseReady),
      .baseValue(baseValue), .baseTag(baseTag), .offset(offset), .robNum(robNum),
      .full(full), .empty(empty),
      .cdbEnable(cdbEnable), .cdbRobNum(cdbRobNum), .cdbData(cdbData),
      .luBusy(luBusy), .loadEnable(loadEnable), .loadType_out(loadType_out),
      .addr_out(addr_out), .robNum_out(robNum_out),
      .excValid(excValid), .excRobNum(excRobNum)
   );

   always #5 clock = ~clock;

   int   n_chk = 0;
   int   n_pass = 0;
   int   issued = 0;
   int   cyc = 0;
   int   last_cyc = -1;
   int   last_gap = 0;
   logic le_prev = 1'b0;
   logic lu_prev = 1'b0;
   exp_t sb[$];
   logic [5:0] xq[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic dispatch(input logic [2:0] t, input logic rdy, input logic [31:0] base,
                           input logic [5:0] tag, input logic [31:0] off, input logic [5:0] rob,
                           input logic [31:0] exp_base, input logic push);
      exp_t e;
      dispatchEnable = 1'b1;
      loadType = t; baseReady = rdy; baseValue = base; baseTag = tag;
      offset = off; robNum = rob;
      if (push) begin
         e.t = t; e.a = exp_base + off; e.r = rob;
         sb.push_back(e);
      end
      tick();
      dispatchEnable = 1'b0;
      baseReady = 1'b0;
   endtask

   task automatic wait_issues(input string tag, input int target, input int budget);
      for (int c = 0; c < budget && issued < target; c++)
         tick();
      chk({tag, "_issued"}, 64'(issued), 64'(target));
   endtask

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (loadEnable === 1'b1) begin
         exp_t e;
         issued++;
         chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
         chk("no_b2b", 64'(le_prev), 64'd0);
         chk("busy_clear", 64'(lu_prev), 64'd0);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("addr_out", 64'(addr_out), 64'(e.a));
            chk("robNum_out", 64'(robNum_out), 64'(e.r));
            chk("loadType_out", 64'(loadType_out), 64'(e.t));
         end
         if (last_cyc >= 0) last_gap = cyc - last_cyc;
         last_cyc = cyc;
      end
      if (excValid === 1'b1) begin
         chk("exc_expected", 64'(xq.size() != 0), 64'd1);
         if (xq.size() != 0) chk("excRobNum", 64'(excRobNum), 64'(xq.pop_front()));
      end
      le_prev = loadEnable;
      lu_prev = luBusy;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      // reset state
      tick(); tick();
      chk("rst_loadEnable", 64'(loadEnable), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_addr", 64'(addr_out), 64'd0);
      chk("rst_rob", 64'(robNum_out), 64'd0);
      chk("rst_exc", 64'(excValid), 64'd0);
      reset_n = 1'b1;
      tick();

      // single ready LW
      dispatch(3'b010, 1'b1, 32'h100, 6'd0, 32'h8, 6'd3, 32'h100, 1'b1);
      chk("t1_le_first", 64'(loadEnable), 64'd0);
      chk("t1_not_empty", 64'(empty), 64'd0);
      tick();
      chk("t1_le_pulse", 64'(loadEnable), 64'd1);
      chk("t1_addr", 64'(addr_out), 64'h108);
      chk("t1_empty", 64'(empty), 64'd1);
      tick();
      chk("t1_le_single", 64'(loadEnable), 64'd0);
      tick(); tick();

      // pending head blocks a ready younger load until the CDB delivers tag 5
      b = issued;
      dispatch(3'b010, 1'b0, 32'h0, 6'd5, 32'h10, 6'd10, 32'h2000, 1'b1);
      dispatch(3'b000, 1'b1, 32'h300, 6'd0, 32'h4, 6'd11, 32'h300, 1'b1);
      repeat (4) tick();
      chk("t2_hold", 64'(issued), 64'(b));
      cdbEnable = 1'b1; cdbRobNum = 6'd5; cdbData = 32'h2000;
      tick();
      cdbEnable = 1'b0;
      chk("t2_cdb_le0", 64'(loadEnable), 64'd0);
      tick();
      chk("t2_cdb_le1", 64'(loadEnable), 64'd1);
      wait_issues("t2", b + 2, 10);
      chk("t2_gap", 64'(last_gap), 64'd2);
      tick(); tick();

      // dispatch-time capture from the same-cycle CDB
      b = issued;
      cdbEnable = 1'b1; cdbRobNum = 6'd7; cdbData = 32'h40;
      dispatch(3'b001, 1'b0, 32'h0, 6'd7, 32'h4, 6'd12, 32'h40, 1'b1);
      cdbEnable = 1'b0;
      tick();
      chk("t3_le", 64'(loadEnable), 64'd1);
      wait_issues("t3", b + 1, 5);
      tick(); tick();

      // fill while busy, overflow dropped, then drain in order
      b = issued;
      luBusy = 1'b1;
      for (int i = 0; i < 4; i++)
         dispatch(3'b100, 1'b1, 32'h1000 * (i + 1), 6'd0, 32'(i), 6'(30 + i), 32'h1000 * (i + 1), 1'b1);
      chk("t4_full", 64'(full), 64'd1);
      dispatch(3'b010, 1'b1, 32'hDEAD0000, 6'd0, 32'h0, 6'd40, 32'h0, 1'b0);
      chk("t4_full_still", 64'(full), 64'd1);
      chk("t4_busy_hold", 64'(issued), 64'(b));
      luBusy = 1'b0;
      wait_issues("t4", b + 4, 20);
      repeat (3) tick();
      chk("t4_empty", 64'(empty), 64'd1);
      chk("t4_sb_drained", 64'(sb.size()), 64'd0);

      // flush with three pending and a same-cycle dispatch
      luBusy = 1'b1;
      for (int i = 0; i < 3; i++)
         dispatch(3'b010, 1'b1, 32'h500, 6'd0, 32'(4 * i), 6'(50 + i), 32'h500, 1'b1);
      flush = 1'b1;
      dispatch(3'b010, 1'b1, 32'h600, 6'd0, 32'h0, 6'd55, 32'h600, 1'b0);
      flush = 1'b0;
      sb.delete();
      b = issued;
      chk("t5_empty", 64'(empty), 64'd1);
      chk("t5_full", 64'(full), 64'd0);
      luBusy = 1'b0;
      repeat (10) tick();
      chk("t5_no_issue", 64'(issued), 64'(b));

      // reset while a load is being issued
      dispatch(3'b000, 1'b1, 32'h700, 6'd0, 32'h1, 6'd60, 32'h700, 1'b1);
      dispatch(3'b000, 1'b1, 32'h800, 6'd0, 32'h2, 6'd61, 32'h800, 1'b1);
      chk("t6_mid_issue", 64'(loadEnable), 64'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      sb.delete();
      b = issued;
      chk("t6_le", 64'(loadEnable), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);
      chk("t6_addr", 64'(addr_out), 64'd0);
      repeat (8) tick();
      chk("t6_no_issue", 64'(issued), 64'(b));

      // misaligned LW followed by an aligned LB
      b = issued;
`ifdef LB_ALIGN_CHECK_EN
      xq.push_back(6'd20);
      dispatch(3'b010, 1'b1, 32'h100, 6'd0, 32'h2, 6'd20, 32'h100, 1'b0);
      dispatch(3'b000, 1'b1, 32'h100, 6'd0, 32'h3, 6'd21, 32'h100, 1'b1);
      wait_issues("t7", b + 1, 10);
      chk("t7_exc_seen", 64'(xq.size()), 64'd0);
`else
      dispatch(3'b010, 1'b1, 32'h100, 6'd0, 32'h2, 6'd20, 32'h100, 1'b1);
      dispatch(3'b000, 1'b1, 32'h100, 6'd0, 32'h3, 6'd21, 32'h100, 1'b1);
      wait_issues("t7", b + 2, 10);
`endif
      repeat (4) tick();
      chk("end_sb_empty", 64'(sb.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
